// File: rtl/add16_arbiter.sv
// add16_arbiter: round-robin front end that time-shares one 16-bit adder
// among NREQ requesters and returns each sum on a valid/ready response
// channel tagged with the owning requester index.
// Optional feature macro: ADD16_ARB_OVF_EN adds the registered signed
// overflow flag rsp_ovf alongside rsp_sum.

// Shared 16-bit adder: plain two's-complement wrap, carry-out dropped.
module add16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);
    // Modulo-2^16 sum; the carry falls off the 16-bit result.
    assign o_sum = i_a + i_b;
endmodule

module add16_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [15:0]        rsp_sum,
`ifdef ADD16_ARB_OVF_EN
    output logic               rsp_ovf,
`endif
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [15:0]     r_a;
    logic [15:0]     r_b;
    logic [IDW-1:0]  r_idx;
    logic [15:0]     r_sum;
    logic [IDW-1:0]  r_id;
    logic            r_rsp_valid;
    logic            r_busy;
`ifdef ADD16_ARB_OVF_EN
    logic            r_ovf;
    logic            w_ovf;
`endif

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_idx;
    logic [15:0]     w_sel_a;
    logic [15:0]     w_sel_b;
    logic [15:0]     w_sum;
    logic            w_accept;
    logic [IDW-1:0]  w_next_ptr;

    // Round-robin search: first pending request at or above r_ptr, wrapping.
    always_comb begin
        logic found;
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        found       = 1'b0;
        w_grant     = '0;
        w_grant_idx = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            automatic int idx = (int'(r_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found        = 1'b1;
                w_grant[idx] = 1'b1;
                w_grant_idx  = IDW'(idx);
                w_sel_a      = req_a[idx*16 +: 16];
                w_sel_b      = req_b[idx*16 +: 16];
            end
        end
    end

    // Grants are only offered in IDLE and never while reset is held; the
    // path depends on registered state only, never on rsp_ready.
    assign req_ready = (r_state == S_IDLE && reset_n) ? w_grant : '0;
    assign w_accept  = |req_ready;

    // Pointer moves to the slot after the requester just served.
    assign w_next_ptr = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);

    add16 u_add16 (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_sum (w_sum)
    );

`ifdef ADD16_ARB_OVF_EN
    // Signed overflow: operands agree in sign but the sum does not.
    assign w_ovf = (r_a[15] == r_b[15]) && (w_sum[15] != r_a[15]);
`endif

    // Main FSM: accept in IDLE, register the sum in ADD, hold it in RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Operand registers are few flops, so they are cleared too;
            // a discarded in-flight result can never resurface.
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef ADD16_ARB_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_idx   <= w_grant_idx;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_sum       <= w_sum;
                    r_id        <= r_idx;
`ifdef ADD16_ARB_OVF_EN
                    r_ovf       <= w_ovf;
`endif
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_ptr       <= w_next_ptr;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_sum;
    assign rsp_id    = r_id;
    assign busy      = r_busy;
`ifdef ADD16_ARB_OVF_EN
    assign rsp_ovf   = r_ovf;
`endif

endmodule
